code_lock_fsm: RTL and testbench
================================

Name: code_lock_fsm

Overview:
- Sequential consumer of the 2-bit equality comparator's `aeqb` output.
- The comparator compares an entered 2-bit key against the expected code digit. This block supplies the digit index that selects that expected digit from an external code ROM/mux.
- Collects a CODE_LEN-digit entry, decides unlock or fail, counts consecutive failures and latches an alarm.
- Moore outputs, all registered.

Parameters:
- CODE_LEN, 4: number of digits per entry attempt (2..2^IDX_W).
- IDX_W, 2: width of `digit_idx`.
- MAX_FAIL, 3: consecutive failed attempts that trigger alarm (1..3).
- UNLOCK_CYCLES, 8: clock cycles `unlocked` stays high (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe: a key digit is presented this cycle.
- aeqb  in  1  comparator result (entered key == code[digit_idx]); sampled only when key_valid=1.
- clear  in  1  abort/relock/alarm-acknowledge.
- digit_idx  out  IDX_W  index of the expected digit; drives code ROM address feeding the comparator's b input.
- unlocked  out  1  high while in UNLOCK.
- alarm  out  1  high while in ALARM.
- fail_cnt  out  2  consecutive failed attempts so far.

Behaviour:
- Reset (synchronous, sampled at clk edge): state=ENTRY, digit_idx=0, internal err=0, fail_cnt=0, unlocked=0, alarm=0, unlock timer=0. Reset has priority over every other input in every state, including mid-entry and mid-unlock.
- States: ENTRY, UNLOCK, ALARM. Outputs derive from registered state/counters only; no combinational input-to-output path.
- ENTRY, key_valid=1, digit_idx < CODE_LEN-1:
  - digit_idx increments.
  - err <= err | ~aeqb. The error is sticky, and no indication is given of which digit was wrong.
- ENTRY, key_valid=1, digit_idx == CODE_LEN-1 (final digit):
  - Success (err=0 and aeqb=1): next state UNLOCK, fail_cnt<=0, timer<=UNLOCK_CYCLES-1.
  - Failure, fail_cnt+1 == MAX_FAIL: next state ALARM, fail_cnt<=MAX_FAIL.
  - Failure otherwise: stay ENTRY, fail_cnt<=fail_cnt+1.
  - In all cases digit_idx<=0 and err<=0.
- ENTRY, key_valid=0: hold.
- ENTRY, clear=1: digit_idx<=0, err<=0, fail_cnt unchanged. clear beats a simultaneous key_valid, and that key is discarded.
- UNLOCK:
  - unlocked=1 for exactly UNLOCK_CYCLES cycles, starting the cycle after the edge that sampled the final good digit.
  - Timer decrements each cycle; at timer==0 the next state is ENTRY.
  - key_valid is ignored; digit_idx is held at 0.
  - clear=1 relocks immediately: next state ENTRY.
- ALARM:
  - alarm=1; key_valid is ignored; digit_idx=0.
  - Only clear=1 (or reset) exits: next state ENTRY, fail_cnt<=0.
- Latency: final key at edge N gives unlocked/alarm/fail_cnt update visible after edge N (one cycle). digit_idx updates after the edge sampling each key.
- Back-to-back key_valid on consecutive cycles must be accepted. The upstream comparator sees the new digit_idx in the same cycle, so aeqb is valid for the next key.
- digit_idx never exceeds CODE_LEN-1; wrap to 0 occurs only at attempt end, clear, or reset.

Test Plan:
- Bench instantiates the 2-bit comparator with b = ROM[digit_idx], using code {1,2,3,0}.
1. Reset, then keys 1,2,3,0 on consecutive cycles → digit_idx 0→1→2→3→0; unlocked=1 for exactly 8 cycles starting the cycle after the 4th key; fail_cnt=0.
2. Keys 1,3,3,0 (wrong second digit) → no unlock, digit_idx back to 0, fail_cnt=1. Then keys 1,2,3,0 → unlock, fail_cnt=0.
3. Three wrong attempts (0,0,0,0 ×3) → fail_cnt 1,2, then alarm=1 after the 12th key. Further correct entry is ignored (alarm stays 1, unlocked=0). clear pulse → alarm=0, fail_cnt=0, ENTRY.
4. Keys 1,2 then clear asserted together with key_valid (key 3) → digit_idx=0, key discarded, fail_cnt unchanged. Then 1,2,3,0 → unlock.
5. During UNLOCK (cycle 3 of 8): key_valid pulses are ignored; clear → unlocked=0 next cycle, state ENTRY.
6. Reset asserted mid-entry (after keys 1,2) and mid-UNLOCK → all outputs 0 next cycle, digit_idx=0; key_valid with reset=1 is not counted.

Source files
------------

// File: rtl/code_lock_if.sv
// Key-entry interface between the keypad/comparator side and the code lock FSM.
// The master drives key strobes and the comparator result; the slave returns the digit index and status.
interface code_lock_if #(
    parameter int IDX_W = 2
);
    logic             key_valid;
    logic             aeqb;
    logic             clear;
    logic [IDX_W-1:0] digit_idx;
    logic             unlocked;
    logic             alarm;
    logic [1:0]       fail_cnt;

    modport master (
        output key_valid,
        output aeqb,
        output clear,
        input  digit_idx,
        input  unlocked,
        input  alarm,
        input  fail_cnt
    );

    modport slave (
        input  key_valid,
        input  aeqb,
        input  clear,
        output digit_idx,
        output unlocked,
        output alarm,
        output fail_cnt
    );
endinterface

// File: rtl/code_lock_fsm.sv
// Multi-digit code lock: walks the code ROM index, tracks a sticky per-attempt error,
// unlocks for a fixed time on a good entry and latches an alarm after repeated failures.
module code_lock_fsm #(
    parameter int CODE_LEN      = 4,
    parameter int IDX_W         = 2,
    parameter int MAX_FAIL      = 3,
    parameter int UNLOCK_CYCLES = 8
) (
    input  logic          clk,
    input  logic          reset,
    code_lock_if.slave    bus
);
    localparam int TMR_W = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);

    typedef enum logic [1:0] {
        ENTRY  = 2'd0,
        UNLOCK = 2'd1,
        ALARM  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic [1:0]       fail_q, fail_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ENTRY;
            idx_q   <= '0;
            err_q   <= 1'b0;
            fail_q  <= 2'd0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        fail_d  = fail_q;
        tmr_d   = tmr_q;
        case (state_q)
            ENTRY: begin
                // clear wins over a simultaneous key, which is dropped
                if (bus.clear) begin
                    idx_d = '0;
                    err_d = 1'b0;
                end else if (bus.key_valid) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        err_d = 1'b0;
                        if (!err_q && bus.aeqb) begin
                            state_d = UNLOCK;
                            fail_d  = 2'd0;
                            tmr_d   = TMR_W'(UNLOCK_CYCLES - 1);
                        end else if (fail_q + 2'd1 == 2'(MAX_FAIL)) begin
                            state_d = ALARM;
                            fail_d  = 2'(MAX_FAIL);
                        end else begin
                            fail_d = fail_q + 2'd1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        err_d = err_q | ~bus.aeqb;
                    end
                end
            end
            UNLOCK: begin
                idx_d = '0;
                if (bus.clear || tmr_q == '0) begin
                    state_d = ENTRY;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ALARM: begin
                idx_d = '0;
                if (bus.clear) begin
                    state_d = ENTRY;
                    fail_d  = 2'd0;
                end
            end
            default: begin
                state_d = ENTRY;
                idx_d   = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    assign bus.digit_idx = idx_q;
    assign bus.unlocked  = (state_q == UNLOCK);
    assign bus.alarm     = (state_q == ALARM);
    assign bus.fail_cnt  = fail_q;
endmodule

// File: tb/tb_code_lock_fsm.sv
// Randomized and directed bench for code_lock_fsm with a 2-bit comparator against code {1,2,3,0}.
// A digit-list reference model predicts the outputs after every clock edge.
module tb_code_lock_fsm;
    localparam int CODE_LEN      = 4;
    localparam int IDX_W         = 2;
    localparam int MAX_FAIL      = 3;
    localparam int UNLOCK_CYCLES = 8;

    logic       clk;
    logic       reset;
    logic [1:0] key;
    logic [1:0] rom [CODE_LEN];

    int n_cmp;
    int n_err;

    // reference model: 0 = entry, 1 = unlocked, 2 = alarm
    int m_mode;
    int m_fails;
    int m_rem;
    int m_digits[$];

    code_lock_if #(.IDX_W(IDX_W)) bus ();

    code_lock_fsm #(
        .CODE_LEN(CODE_LEN),
        .IDX_W(IDX_W),
        .MAX_FAIL(MAX_FAIL),
        .UNLOCK_CYCLES(UNLOCK_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    assign bus.aeqb = (key == rom[bus.digit_idx]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit entry_matches();
        for (int i = 0; i < CODE_LEN; i++)
            if (m_digits[i] != int'(rom[i])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input logic r, input logic kv, input logic [1:0] k, input logic c);
        if (r) begin
            m_mode = 0; m_fails = 0; m_rem = 0; m_digits.delete();
        end else if (m_mode == 0) begin
            if (c) begin
                m_digits.delete();
            end else if (kv) begin
                m_digits.push_back(int'(k));
                if (m_digits.size() == CODE_LEN) begin
                    if (entry_matches()) begin
                        m_mode = 1; m_rem = UNLOCK_CYCLES; m_fails = 0;
                    end else if (m_fails + 1 == MAX_FAIL) begin
                        m_mode = 2; m_fails = MAX_FAIL;
                    end else begin
                        m_fails++;
                    end
                    m_digits.delete();
                end
            end
        end else if (m_mode == 1) begin
            m_rem--;
            if (c || m_rem == 0) m_mode = 0;
        end else begin
            if (c) begin
                m_mode = 0; m_fails = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("digit_idx", int'(bus.digit_idx), (m_mode == 0) ? m_digits.size() : 0);
        chk("unlocked",  int'(bus.unlocked),  (m_mode == 1) ? 1 : 0);
        chk("alarm",     int'(bus.alarm),     (m_mode == 2) ? 1 : 0);
        chk("fail_cnt",  int'(bus.fail_cnt),  m_fails);
    endtask

    task automatic step(input logic r, input logic kv, input logic [1:0] k, input logic c);
        @(negedge clk);
        reset = r; bus.key_valid = kv; key = k; bus.clear = c;
        @(posedge clk);
        model_step(r, kv, k, c);
        #1;
        check_outputs();
    endtask

    task automatic keys4(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c, input logic [1:0] d);
        step(1'b0, 1'b1, a, 1'b0);
        step(1'b0, 1'b1, b, 1'b0);
        step(1'b0, 1'b1, c, 1'b0);
        step(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        logic r, kv, c;
        logic [1:0] k;
        n_cmp = 0; n_err = 0;
        m_mode = 0; m_fails = 0; m_rem = 0;
        rom[0] = 2'd1; rom[1] = 2'd2; rom[2] = 2'd3; rom[3] = 2'd0;
        reset = 1'b1; bus.key_valid = 1'b0; bus.clear = 1'b0; key = 2'd0;

        step(1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b1, 2'd1, 1'b0);

        // good entry, unlock window expires
        keys4(2'd1, 2'd2, 2'd3, 2'd0);
        idle(10);
        // wrong second digit, then good
        keys4(2'd1, 2'd3, 2'd3, 2'd0);
        keys4(2'd1, 2'd2, 2'd3, 2'd0);
        idle(9);
        // three failures into alarm, correct code ignored, clear exits
        keys4(2'd0, 2'd0, 2'd0, 2'd0);
        keys4(2'd0, 2'd0, 2'd0, 2'd0);
        keys4(2'd0, 2'd0, 2'd0, 2'd0);
        keys4(2'd1, 2'd2, 2'd3, 2'd0);
        step(1'b0, 1'b0, 2'd0, 1'b1);
        idle(1);
        // clear colliding with a key
        step(1'b0, 1'b1, 2'd1, 1'b0);
        step(1'b0, 1'b1, 2'd2, 1'b0);
        step(1'b0, 1'b1, 2'd3, 1'b1);
        keys4(2'd1, 2'd2, 2'd3, 2'd0);
        // keys ignored while unlocked, then clear relocks
        step(1'b0, 1'b1, 2'd1, 1'b0);
        step(1'b0, 1'b1, 2'd2, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b1);
        idle(1);
        // reset mid-entry and mid-unlock
        step(1'b0, 1'b1, 2'd1, 1'b0);
        step(1'b0, 1'b1, 2'd2, 1'b0);
        step(1'b1, 1'b1, 2'd3, 1'b0);
        keys4(2'd1, 2'd2, 2'd3, 2'd0);
        idle(2);
        step(1'b1, 1'b1, 2'd1, 1'b0);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            c  = ($urandom_range(0, 29) == 0);
            kv = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 4) != 0 && m_mode == 0)
                k = rom[m_digits.size()];
            else
                k = 2'($urandom_range(0, 3));
            step(r, kv, k, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
